// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall/flush controller for a 5-stage in-order pipeline.
// Resolves memory back-pressure, taken-branch redirects and load-use hazards
// into stage-register enables and bubble-insert flushes. Outputs are
// combinational (zero latency) from the current state and inputs.
// Optional feature: define PIPELINE_CTRL_PERF_CNT_EN to build the saturating
// stall/flush performance counters; otherwise both counter outputs are tied to 0.
module pipeline_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      redirect_valid,
  input  logic                      mem_busy,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      id_ex_en,
  output logic                      ex_mem_en,
  output logic                      mem_wb_en,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  // FLUSH_PEND remembers a redirect that arrived while memory was busy,
  // so the redirect is applied once the pipeline can move again.
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    FLUSH_PEND = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;
  logic   load_use;
  logic   do_redirect;

  // Load-use hazard: a load in EX writes a register that ID is about to read.
  // Register 0 is hardwired, so a load "to" it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // A redirect is either fresh this cycle or pending from a busy period.
  assign do_redirect = redirect_valid || (state_reg == FLUSH_PEND);

  // State register; reset discards any pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and output decode: mem_busy > redirect > load-use hazard.
  always_comb begin
    state_next  = RUN;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst) begin
      state_next = RUN;
    end else if (mem_busy) begin
      // Freeze everything; keep remembering a redirect if one is outstanding.
      state_next = do_redirect ? FLUSH_PEND : MEM_WAIT;
    end else if (do_redirect) begin
      // Wrong-path instructions in IF/ID and ID/EX become bubbles; a stage
      // being flushed must also be enabled so the bubble is actually loaded.
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, inject a bubble into EX, let the load proceed.
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
    end
  end

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] stall_cnt_reg;
  logic [CNT_WIDTH-1:0] flush_cnt_reg;

  // Saturating counters: cycles with PC held, and cycles with any flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (!pc_en && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_ONE;
      end
      if ((if_id_flush || id_ex_flush) && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed-vector bench for pipeline_ctrl (CNT_WIDTH=4 so
// counter saturation is reachable). Expected counter values come from a small
// saturating model; with the perf-counter macro undefined they must read 0.
module tb_pipeline_ctrl;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic [AW-1:0] ex_rd;
  logic          ex_mem_read;
  logic          redirect_valid;
  logic          mem_busy;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  logic [6:0]    outs;
  int            checks_total;
  int            checks_passed;
  int            exp_stall;
  int            exp_flush;

  // Output vector order: pc, if_id, id_ex, ex_mem, mem_wb enables, if_id/id_ex flush.
  localparam logic [6:0] V_ZERO   = 7'b0000000;
  localparam logic [6:0] V_RUN    = 7'b1111100;
  localparam logic [6:0] V_HAZ    = 7'b0011101;
  localparam logic [6:0] V_REDIR  = 7'b1111111;

  pipeline_ctrl #(
    .REG_ADDR_WIDTH(AW),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .redirect_valid(redirect_valid),
    .mem_busy      (mem_busy),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus: check outputs and counters mid-cycle, advance the
  // counter model using the expected outputs, then step past the next edge.
  task automatic cycle(input string tag, input logic [6:0] exp_vec);
    int es;
    int ef;
    @(negedge clk);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    es = exp_stall;
    ef = exp_flush;
`else
    es = 0;
    ef = 0;
`endif
    $display("cycle %-12s rst=%0b busy=%0b redir=%0b outs=%07b stall=%0d flush=%0d",
             tag, rst, mem_busy, redirect_valid, outs, stall_cnt, flush_cnt);
    check({tag, ".outs"}, {25'd0, outs}, {25'd0, exp_vec});
    check({tag, ".stall_cnt"}, {28'd0, stall_cnt}, es);
    check({tag, ".flush_cnt"}, {28'd0, flush_cnt}, ef);
    if (rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!exp_vec[6] && exp_stall < CNT_MAX) exp_stall++;
      if ((exp_vec[1] || exp_vec[0]) && exp_flush < CNT_MAX) exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic busy, input logic redir,
                        input logic rd_mem, input logic [AW-1:0] rd,
                        input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    rst            = r;
    mem_busy       = busy;
    redirect_valid = redir;
    ex_mem_read    = rd_mem;
    ex_rd          = rd;
    id_rs1         = rs1;
    id_rs2         = rs2;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    exp_stall     = 0;
    exp_flush     = 0;
    set_in(1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cycle("reset0", V_ZERO);
    // Reset dominates even a redirect request.
    set_in(1, 0, 1, 0, 0, 0, 0);
    cycle("reset_redir", V_ZERO);

    set_in(0, 0, 0, 0, 0, 1, 2);
    cycle("run", V_RUN);
    // Load-use through rs2, then hazard gone.
    set_in(0, 0, 0, 1, 5, 1, 5);
    cycle("lu_rs2", V_HAZ);
    set_in(0, 0, 0, 0, 5, 1, 5);
    cycle("lu_clear", V_RUN);
    // Load to x0 never stalls.
    set_in(0, 0, 0, 1, 0, 0, 0);
    cycle("lu_x0", V_RUN);
    // Load-use through rs1.
    set_in(0, 0, 0, 1, 3, 3, 7);
    cycle("lu_rs1", V_HAZ);
    // Matching register but not a load.
    set_in(0, 0, 0, 0, 3, 3, 3);
    cycle("no_load", V_RUN);
    // Redirect alone and redirect overriding a hazard.
    set_in(0, 0, 1, 0, 0, 0, 0);
    cycle("redir", V_REDIR);
    set_in(0, 0, 1, 1, 4, 4, 0);
    cycle("redir_haz", V_REDIR);

    // Busy for 3 cycles with redirect in the first, from a fresh reset.
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle("reset1", V_ZERO);
    set_in(0, 1, 1, 0, 0, 0, 0);
    cycle("busy1", V_ZERO);
    set_in(0, 1, 0, 0, 0, 0, 0);
    cycle("busy2", V_ZERO);
    cycle("busy3", V_ZERO);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle("pend_flush", V_REDIR);
    cycle("after_pend", V_RUN);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    check("req032.stall", {28'd0, stall_cnt}, 32'd3);
    check("req032.flush", {28'd0, flush_cnt}, 32'd1);
`else
    check("req032.stall", {28'd0, stall_cnt}, 32'd0);
    check("req032.flush", {28'd0, flush_cnt}, 32'd0);
`endif

    // MEM_WAIT exit evaluates as RUN: a hazard present on exit stalls.
    set_in(0, 1, 0, 1, 6, 6, 0);
    cycle("wait_busy", V_ZERO);
    set_in(0, 0, 0, 1, 6, 6, 0);
    cycle("wait_haz", V_HAZ);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle("wait_done", V_RUN);

    // Reset while a redirect is pending discards it.
    set_in(0, 1, 1, 0, 0, 0, 0);
    cycle("pend_a", V_ZERO);
    set_in(0, 1, 0, 0, 0, 0, 0);
    cycle("pend_b", V_ZERO);
    set_in(1, 1, 0, 0, 0, 0, 0);
    cycle("pend_rst", V_ZERO);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle("post_rst", V_RUN);
    cycle("post_rst2", V_RUN);

    // Saturation: 20 hazard stall cycles against a 4-bit counter.
    set_in(1, 0, 0, 0, 0, 0, 0);
    cycle("reset2", V_ZERO);
    set_in(0, 0, 0, 1, 9, 0, 9);
    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("sat%0d", i), V_HAZ);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    cycle("sat_end", V_RUN);
`ifdef PIPELINE_CTRL_PERF_CNT_EN
    check("req034.stall", {28'd0, stall_cnt}, CNT_MAX);
`else
    check("req034.stall", {28'd0, stall_cnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
